pcm_pdm_modulator: RTL

Transmit-side counterpart of the PDM-to-PCM decimator: it converts a stream of signed PCM samples into a 1-bit PDM bitstream.
- Samples arrive over valid/ready and are buffered in a small FIFO.
- Each sample is held for INTERPOLATION_RATIO output bits (zero-order hold).
- A first-order delta-sigma modulator produces the bits, which leave over a per-bit valid/ready handshake.
- Round trip through the decimator at the same ratio reproduces the quantised PCM value.

---
 rtl/pdm_pcm_converter_pkg.sv | 22 ++
 rtl/pcm_pdm_sample_fifo.sv | 81 ++++++++
 rtl/pcm_pdm_modulator.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pdm_pcm_converter_pkg.sv
// Shared definitions for the PCM<->PDM converter pair: defaults, modulator states
// and the signed-to-offset-binary helper used by both directions.
package pdm_pcm_converter_pkg;

    localparam int DEFAULT_DATA_WIDTH          = 16;
    localparam int DEFAULT_INTERPOLATION_RATIO = 16;
    localparam int DEFAULT_FIFO_DEPTH          = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } mod_state_e;

    // Flip the sign bit of a width-bit two's complement value held in the low bits.
    function automatic logic [31:0] to_offset_binary(input logic [31:0] sample,
                                                     input int unsigned width);
        logic [31:0] mask;
        mask = 32'd1 << (width - 32'd1);
        return sample ^ mask;
    endfunction

endpackage

// File: rtl/pcm_pdm_sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy output; the head entry is
// visible on data_o whenever empty_o is low.
module pcm_pdm_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o   = (level_q == LW'(0));
    assign full_o    = (level_q == LW'(DEPTH));
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage, cleared on reset so no stale data survives a reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pcm_pdm_modulator.sv
// PCM-to-PDM modulator: buffers signed samples, holds each for RATIO output bits
// and produces them with a first-order delta-sigma loop over a valid/ready port.
module pcm_pdm_modulator
    import pdm_pcm_converter_pkg::*;
#(
    parameter int PDM_PCM_CONVERTER_DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int PDM_PCM_CONVERTER_INTERPOLATION_RATIO = DEFAULT_INTERPOLATION_RATIO,
    parameter int PDM_PCM_CONVERTER_FIFO_DEPTH          = DEFAULT_FIFO_DEPTH
) (
    input  logic                                          clock_i,
    input  logic                                          reset_n_i,
    input  logic [PDM_PCM_CONVERTER_DATA_WIDTH-1:0]       pcm_data_i,
    input  logic                                          pcm_valid_i,
    output logic                                          pcm_ready_o,
    output logic                                          pdm_data_o,
    output logic                                          pdm_valid_o,
    input  logic                                          pdm_ready_i,
    input  logic                                          enable_i,
    output logic                                          busy_o,
    output logic                                          underflow_o,
    output logic [$clog2(PDM_PCM_CONVERTER_FIFO_DEPTH):0] fifo_level_o
);

    localparam int DW    = PDM_PCM_CONVERTER_DATA_WIDTH;
    localparam int RATIO = PDM_PCM_CONVERTER_INTERPOLATION_RATIO;
    localparam int DEPTH = PDM_PCM_CONVERTER_FIFO_DEPTH;
    localparam int CW    = $clog2(RATIO);

    localparam logic [CW-1:0] LAST_BIT = CW'(RATIO - 1);
    // Offset-binary midscale, i.e. PCM 0, used when a frame starts with nothing queued.
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

    mod_state_e    state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cur_u_q, cur_u_d;
    logic          pdm_bit_q, pdm_bit_d;
    logic          pdm_valid_q, pdm_valid_d;
    logic          underflow_q, underflow_d;

    logic [DW-1:0] fifo_data_s;
    logic [DW-1:0] fifo_u_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          push_s;
    logic          pop_s;
    logic          load_bit_s;
    logic [DW-1:0] u_sel_s;
    logic [DW:0]   sum_s;

    assign pcm_ready_o  = enable_i && !fifo_full_s;
    assign push_s       = pcm_valid_i && pcm_ready_o;
    assign fifo_u_s     = DW'(to_offset_binary(32'(fifo_data_s), DW));

    pcm_pdm_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .push_i    (push_s),
        .data_i    (pcm_data_i),
        .pop_i     (pop_s),
        .data_o    (fifo_data_s),
        .empty_o   (fifo_empty_s),
        .full_o    (fifo_full_s),
        .level_o   (fifo_level_o)
    );

    // FSM next-state, frame sequencing and delta-sigma bit generation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cur_u_d     = cur_u_q;
        pdm_bit_d   = pdm_bit_q;
        pdm_valid_d = pdm_valid_q;
        underflow_d = underflow_q;
        pop_s       = 1'b0;
        load_bit_s  = 1'b0;
        u_sel_s     = cur_u_q;
        sum_s       = '0;

        case (state_q)
            IDLE: begin
                if (enable_i && !fifo_empty_s) begin
                    pop_s       = 1'b1;
                    u_sel_s     = fifo_u_s;
                    cur_u_d     = fifo_u_s;
                    cnt_d       = '0;
                    pdm_valid_d = 1'b1;
                    load_bit_s  = 1'b1;
                    state_d     = ACTIVE;
                end else begin
                    underflow_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (!enable_i) begin
                    state_d     = IDLE;
                    pdm_valid_d = 1'b0;
                    pdm_bit_d   = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    underflow_d = 1'b0;
                end else if (pdm_ready_i) begin
                    load_bit_s = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
                        if (!fifo_empty_s) begin
                            pop_s   = 1'b1;
                            u_sel_s = fifo_u_s;
                            cur_u_d = fifo_u_s;
                        end else begin
                            u_sel_s     = MIDSCALE;
                            cur_u_d     = MIDSCALE;
                            underflow_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    load_bit_s = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                pdm_valid_d = 1'b0;
                pdm_bit_d   = 1'b0;
                acc_d       = '0;
                cnt_d       = '0;
                underflow_d = 1'b0;
            end
        endcase

        // The carry out of the accumulator is the output bit; the remainder feeds back.
        sum_s = {1'b0, acc_q} + {1'b0, u_sel_s};
        if (load_bit_s) begin
            pdm_bit_d = sum_s[DW];
            acc_d     = sum_s[DW-1:0];
        end else begin
            sum_s = sum_s;
        end
    end

    // State, accumulator, counter and output registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            cur_u_q     <= '0;
            pdm_bit_q   <= 1'b0;
            pdm_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cur_u_q     <= cur_u_d;
            pdm_bit_q   <= pdm_bit_d;
            pdm_valid_q <= pdm_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign pdm_data_o  = pdm_bit_q;
    assign pdm_valid_o = pdm_valid_q;
    assign underflow_o = underflow_q;
    assign busy_o      = (state_q == ACTIVE);

endmodule
